// File: rtl/ula_result_sel.sv
// Registered ULA result selector: picks one unit's result by opcode, waits for its
// done strobe (with timeout), and holds the result under a valid/ready handshake.
module ula_result_sel #(
    parameter  int WIDTH   = 8,
    parameter  int NUM_OPS = 8,
    parameter  int TIMEOUT = 15,
    localparam int SEL_W   = $clog2(NUM_OPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_OPS*WIDTH-1:0] op_data,
    input  logic [NUM_OPS-1:0]       op_done,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     start,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         result,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     err,
    output logic                     zero
);

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [7:0]         timer, timer_d;
    logic [WIDTH-1:0]   result_d;
    logic               err_d, zero_d;
    logic [WIDTH-1:0]   slice;

    always_comb begin
        slice = '0;
        for (int unsigned i = 0; i < NUM_OPS; i++) begin
            if (sel_q == SEL_W'(i)) slice = op_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d  = state;
        sel_d    = sel_q;
        timer_d  = timer;
        result_d = result;
        err_d    = err;
        zero_d   = zero;

        // A HOLD that completes with start high launches exactly like IDLE.
        if ((state == IDLE && start) || (state == HOLD && out_ready && start)) begin
            if (sel != '0) begin
                sel_d   = sel;
                timer_d = '0;
                state_d = WAIT;
            end else begin
                result_d = '0;
                err_d    = 1'b1;
                zero_d   = 1'b1;
                state_d  = HOLD;
            end
        end else begin
            case (state)
                IDLE: state_d = IDLE;
                WAIT: begin
                    if (op_done[sel_q]) begin
                        result_d = slice;
                        err_d    = 1'b0;
                        zero_d   = (slice == '0);
                        state_d  = HOLD;
                    end else if (timer == TMAX) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        zero_d   = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        timer_d = timer + 8'd1;
                    end
                end
                HOLD: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel_q  <= '0;
            timer  <= '0;
            result <= '0;
            err    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            state  <= state_d;
            sel_q  <= sel_d;
            timer  <= timer_d;
            result <= result_d;
            err    <= err_d;
            zero   <= zero_d;
        end
    end

    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ula_result_sel.sv
// Self-checking bench for ula_result_sel: directed and random requests compared
// against an outcome/latency model derived from the selection rules.
module tb_ula_result_sel;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int T  = 15;
    localparam int W2 = 16;
    localparam int N2 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic [N*W-1:0] op_data = '0;
    logic [N-1:0]   op_done = '0;
    logic [2:0]     sel = '0;
    logic           start = 1'b0, out_ready = 1'b0;
    logic [W-1:0]   result;
    logic           out_valid, busy, err, zero;

    logic [N2*W2-1:0] p_op_data = '0;
    logic [N2-1:0]    p_op_done = '0;
    logic [1:0]       p_sel = '0;
    logic             p_start = 1'b0, p_out_ready = 1'b0;
    logic [W2-1:0]    p_result;
    logic             p_out_valid, p_busy, p_err, p_zero;

    ula_result_sel #(.WIDTH(W), .NUM_OPS(N), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .op_data(op_data), .op_done(op_done), .sel(sel),
        .start(start), .out_ready(out_ready), .result(result), .out_valid(out_valid),
        .busy(busy), .err(err), .zero(zero)
    );

    ula_result_sel #(.WIDTH(W2), .NUM_OPS(N2), .TIMEOUT(T)) dut_p (
        .clk(clk), .rst_n(rst_n), .op_data(p_op_data), .op_done(p_op_done), .sel(p_sel),
        .start(p_start), .out_ready(p_out_ready), .result(p_result), .out_valid(p_out_valid),
        .busy(p_busy), .err(p_err), .zero(p_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         cur_s, cur_d, lat;
    logic [7:0] cur_data, exp_res;
    logic       exp_err, exp_zero;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Model: reserved opcode answers after 1 edge; otherwise op_done seen in WAIT
    // cycle d+1 wins if that cycle is within the TIMEOUT budget, else error.
    task automatic issue(input int s, input int d, input logic [7:0] data);
        cur_s = s; cur_d = d; cur_data = data;
        if (s == 0)     lat = 1;
        else if (d < T) lat = d + 2;
        else            lat = T + 1;
        exp_err  = (s == 0) || (d >= T);
        exp_res  = exp_err ? 8'h00 : data;
        exp_zero = (exp_res == 8'h00);
        start   = 1'b1;
        sel     = 3'(s);
        op_data = rnd64();
        op_done = 8'($urandom());
    endtask

    task automatic check_hold();
        chk("hold_valid", out_valid, 1);
        chk("hold_busy", busy, 1);
        chk("hold_result", result, exp_res);
        chk("hold_err", err, exp_err);
        chk("hold_zero", zero, exp_zero);
    endtask

    task automatic finish_txn();
        for (int k = 1; k < lat; k++) begin
            tick();
            chk("wait_busy", busy, 1);
            chk("wait_valid", out_valid, 0);
            start     = 1'($urandom() % 2);
            sel       = 3'($urandom());
            out_ready = 1'($urandom() % 2);
            op_data   = rnd64();
            op_done   = 8'($urandom());
            op_done[cur_s] = (k == cur_d + 1);
            if (k == cur_d + 1) op_data[cur_s*W +: W] = cur_data;
        end
        tick();
        check_hold();
    endtask

    task automatic stall(input int n);
        for (int k = 0; k < n; k++) begin
            out_ready = 1'b0;
            start     = 1'b1;
            sel       = 3'($urandom());
            op_data   = rnd64();
            op_done   = 8'($urandom());
            tick();
            check_hold();
        end
    endtask

    task automatic release_idle();
        out_ready = 1'b1;
        start     = 1'b0;
        sel       = 3'($urandom());
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_zero"}, zero, 0);
    endtask

    initial begin
        int  s, d;
        logic [7:0] data;
        bit  chain;

        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst");
        chk("rst_p_valid", p_out_valid, 0);
        chk("rst_p_result", p_result, 0);
        tick();
        @(negedge clk) rst_n = 1'b1;

        // combinational op
        out_ready = 1'b1;
        issue(1, 0, 8'hA5);
        finish_txn();
        release_idle();

        // multi-cycle op with zero result and stalled consumer
        issue(4, 4, 8'h00);
        finish_txn();
        stall(3);
        release_idle();

        // reserved opcode
        issue(0, 0, 8'hFF);
        finish_txn();
        release_idle();

        // timeout, then done on the last allowed WAIT cycle
        issue(3, T, 8'h5A);
        finish_txn();
        release_idle();
        issue(3, T - 1, 8'h77);
        finish_txn();
        release_idle();

        // back-to-back with no IDLE bubble
        issue(2, 1, 8'h11);
        finish_txn();
        out_ready = 1'b1;
        issue(7, 0, 8'h3C);
        finish_txn();
        release_idle();

        // reset mid-WAIT aborts the request
        issue(3, 100, 8'h55);
        tick();
        tick();
        tick();
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        start = 1'b0;
        tick();
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            op_done = '1;
            tick();
            check_reset_vals("post_rst");
        end

        // random requests
        out_ready = 1'b1;
        chain = 1'b0;
        for (int i = 0; i < 40; i++) begin
            s    = int'($urandom_range(0, N - 1));
            d    = int'($urandom_range(0, T + 3));
            data = ($urandom() % 4 == 0) ? 8'h00 : 8'($urandom());
            issue(s, d, data);
            finish_txn();
            stall(int'($urandom_range(0, 2)));
            chain = 1'($urandom() % 2);
            if (!chain) release_idle();
            else        out_ready = 1'b1;
        end
        if (chain) release_idle();

        // 16-bit, 4-op instance
        p_out_ready = 1'b1;
        p_sel       = 2'd3;
        p_op_data   = rnd64();
        p_op_data[3*W2 +: W2] = 16'hBEEF;
        p_op_done   = 4'hF;
        p_start     = 1'b1;
        tick();
        p_start = 1'b0;
        chk("p_wait_busy", p_busy, 1);
        chk("p_wait_valid", p_out_valid, 0);
        tick();
        chk("p_valid", p_out_valid, 1);
        chk("p_result", p_result, 16'hBEEF);
        chk("p_err", p_err, 0);
        chk("p_zero", p_zero, 0);
        tick();
        chk("p_idle", p_busy, 0);
        p_sel   = 2'd0;
        p_start = 1'b1;
        tick();
        p_start = 1'b0;
        chk("p_rsv_valid", p_out_valid, 1);
        chk("p_rsv_err", p_err, 1);
        chk("p_rsv_result", p_result, 0);
        chk("p_rsv_zero", p_zero, 1);
        tick();
        chk("p_rsv_idle", p_out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
